// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with tick prescaler, sync load, wrap pulse and active-low 7-seg decode.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_counter_display #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned DIV_EXP = 22
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   seg7_out,
    output logic                  dpt_out,
    output logic                  tc,
    output logic                  wrap,
    output logic                  tick
);

    logic [DIV_EXP-1:0]  presc_q, presc_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic                wrap_q, wrap_d;
    logic                all_nine, all_zero, step;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        unique case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (count_q[4*k +: 4] != 4'd9) all_nine = 1'b0;
            if (count_q[4*k +: 4] != 4'd0) all_zero = 1'b0;
        end
    end

    assign tick    = &presc_q;
    assign step    = tick & enable & ~load;
    assign tc      = up_dn ? all_nine : all_zero;
    assign count   = count_q;
    assign wrap    = wrap_q;
    assign dpt_out = 1'b1;

    always_comb begin
        logic       carry;
        logic [3:0] dig;
        presc_d = presc_q + 1'b1;
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = 1'b1;
        dig     = 4'd0;
        if (load) begin
            presc_d = '0;
            for (int k = 0; k < int'(DIGITS); k++) begin
                dig = load_val[4*k +: 4];
                count_d[4*k +: 4] = (dig > 4'd9) ? 4'd0 : dig;
            end
        end else if (step) begin
            // Ripple carry/borrow from digit 0 upward.
            for (int k = 0; k < int'(DIGITS); k++) begin
                dig = count_q[4*k +: 4];
                if (carry) begin
                    if (up_dn) begin
                        if (dig == 4'd9) dig = 4'd0;
                        else begin
                            dig   = dig + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) dig = 4'd9;
                        else begin
                            dig   = dig - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
                count_d[4*k +: 4] = dig;
            end
            wrap_d = up_dn ? all_nine : all_zero;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        seg7_out = '1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            seg7_out[7*k +: 7] = seg_decode(count_q[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            lead = lead & (count_q[4*k +: 4] == 4'd0);
            if (k != 0 && lead) seg7_out[7*k +: 7] = 7'h7F;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Scoreboard bench for bcd_counter_display (DIGITS=2, DIV_EXP=2): stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_bcd_counter_display;

    localparam int KCount = 0, KSeg = 1, KWrap = 2, KTick = 3, KTc = 4, KTickCnt = 5, KDpt = 6;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        reset, enable, up_dn, load;
    logic [7:0]  load_val;
    logic [7:0]  count;
    logic [13:0] seg7_out;
    logic        dpt_out, tc, wrap, tick;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   tick_cnt = 0;
    bit   tick_en = 1'b0;
    bit   done = 1'b0;

    bcd_counter_display #(.DIGITS(2), .DIV_EXP(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .seg7_out (seg7_out),
        .dpt_out  (dpt_out),
        .tc       (tc),
        .wrap     (wrap),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tick_en && tick) tick_cnt++;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            KCount:   actual = {24'd0, count};
            KSeg:     actual = {18'd0, seg7_out};
            KWrap:    actual = {31'd0, wrap};
            KTick:    actual = {31'd0, tick};
            KTc:      actual = {31'd0, tc};
            KTickCnt: actual = tick_cnt;
            default:  actual = {31'd0, dpt_out};
        endcase
    endfunction

    // Monitor: compare everything queued since the last rising edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t c;
            logic [31:0] a;
            c = q.pop_front();
            a = actual(c.kind);
            checks++;
            if (a !== c.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", c.name, a, c.exp, $time);
            end
        end
    end

    // Watchdog: the stimulus must complete within a bounded time.
    initial begin
        #20000;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: stimulus did not complete by %0t", $time);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic expect_v(input string name, input int kind, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [31:0] Seg05 = 32'h3F92;
`else
    localparam logic [31:0] Seg05 = 32'h2012;
`endif

    initial begin
        reset = 1'b1; enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
        cyc(2);
        expect_v("rst_count", KCount, 32'h00);
        expect_v("rst_seg", KSeg, 32'h2040);
        expect_v("rst_wrap", KWrap, 32'h0);
        expect_v("rst_tick", KTick, 32'h0);
        expect_v("rst_tc_up", KTc, 32'h0);
        expect_v("dpt", KDpt, 32'h1);
        cyc(1);
        up_dn = 1'b0;
        #1;
        expect_v("rst_tc_dn", KTc, 32'h1);
        cyc(1);

        // Free-running up count: 40 edges -> 10 steps
        up_dn = 1'b1; enable = 1'b1; reset = 1'b0; tick_cnt = 0; tick_en = 1'b1;
        cyc(40);
        tick_en = 1'b0;
        expect_v("up40_count", KCount, 32'h10);
        expect_v("up40_seg", KSeg, 32'h3CC0);
        expect_v("up40_ticks", KTickCnt, 32'd10);

        // Wrap up from 99
        load = 1'b1; load_val = 8'h99;
        cyc(1);
        load = 1'b0;
        expect_v("ld99_count", KCount, 32'h99);
        expect_v("ld99_tc", KTc, 32'h1);
        expect_v("ld99_wrap", KWrap, 32'h0);
        cyc(3);
        expect_v("pre_wrapup_count", KCount, 32'h99);
        expect_v("pre_wrapup_tick", KTick, 32'h1);
        cyc(1);
        expect_v("wrapup_count", KCount, 32'h00);
        expect_v("wrapup_wrap", KWrap, 32'h1);
        cyc(1);
        expect_v("wrapup_wrap_clr", KWrap, 32'h0);

        // Wrap down from 00
        load = 1'b1; load_val = 8'h00; up_dn = 1'b0;
        cyc(1);
        load = 1'b0;
        expect_v("ld00_tc", KTc, 32'h1);
        cyc(3);
        expect_v("pre_wrapdn_count", KCount, 32'h00);
        expect_v("pre_wrapdn_tick", KTick, 32'h1);
        cyc(1);
        expect_v("wrapdn_count", KCount, 32'h99);
        expect_v("wrapdn_wrap", KWrap, 32'h1);
        expect_v("wrapdn_tc", KTc, 32'h0);
        cyc(1);
        expect_v("wrapdn_wrap_clr", KWrap, 32'h0);

        // Sanitising load and blanking view
        load = 1'b1; load_val = 8'hA5;
        cyc(1);
        load = 1'b0; up_dn = 1'b1;
        expect_v("ldA5_count", KCount, 32'h05);
        expect_v("ldA5_seg", KSeg, Seg05);

        // Load on a tick cycle wins and clears the prescaler
        cyc(3);
        expect_v("pre_ldtick_tick", KTick, 32'h1);
        load = 1'b1; load_val = 8'h42;
        cyc(1);
        load = 1'b0;
        expect_v("ldtick_count", KCount, 32'h42);
        expect_v("ldtick_tick", KTick, 32'h0);
        cyc(2);
        expect_v("ldtick_tick2", KTick, 32'h0);
        cyc(1);
        expect_v("ldtick_tick3", KTick, 32'h1);
        expect_v("ldtick_hold", KCount, 32'h42);
        cyc(1);
        expect_v("ldtick_step", KCount, 32'h43);

        // Enable low for 20 edges with up_dn toggling
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_dn = ~up_dn;
            cyc(5);
            expect_v("hold_count", KCount, 32'h43);
            expect_v("hold_wrap", KWrap, 32'h0);
        end

        // up_dn toggles between ticks only matter on the stepping edge
        enable = 1'b1; up_dn = 1'b1;
        cyc(1);
        up_dn = 1'b0;
        cyc(1);
        up_dn = 1'b1;
        cyc(1);
        expect_v("toggle_hold", KCount, 32'h43);
        up_dn = 1'b0;
        cyc(1);
        expect_v("toggle_step_dn", KCount, 32'h42);

        // Asynchronous reset mid-count, checked before the next edge
        cyc(2);
        reset = 1'b1;
        #1;
        checks++;
        if (count !== 8'h00 || seg7_out !== 14'h2040 || wrap !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL async_direct: count=0x%0h seg=0x%0h wrap=%b tick=%b at %0t",
                     count, seg7_out, wrap, tick, $time);
        end
        expect_v("async_count", KCount, 32'h00);
        expect_v("async_seg", KSeg, 32'h2040);
        expect_v("async_wrap", KWrap, 32'h0);
        expect_v("async_tick", KTick, 32'h0);
        cyc(1);
        reset = 1'b0; up_dn = 1'b1;
        cyc(3);
        expect_v("post_rst_hold", KCount, 32'h00);
        cyc(1);
        expect_v("post_rst_step", KCount, 32'h01);

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_counter_display.md
# bcd_counter_display

Parametrised N-digit BCD up/down counter with built-in tick prescaler, synchronous load, wrap detection and per-digit active-low seven-segment decode. It is the board-level successor to the single-digit 0–9 display counter. It sits directly between the board clock/switches and the HEX displays, DIGITS ≤ 6 on the DE10-Lite.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits; legal 1..6.
- DIV_EXP, 22, prescaler width; one count step per 2^DIV_EXP clk cycles; legal 1..26.

Ports:
- clk  in  1  board clock; all state is updated on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  high allows the count to step on a tick.
- up_dn  in  1  1 = count up, 0 = count down; sampled on the stepping edge.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD load value; digit k is at [4k+3:4k].
- count  out  4*DIGITS  registered BCD count.
- seg7_out  out  7*DIGITS  active-low segments; digit k is at [7k+6:7k], with bit 0 = a … bit 6 = g.
- dpt_out  out  1  decimal point, constant 1 (off).
- tc  out  1  combinational terminal count: all digits 9 when up_dn=1, all digits 0 when up_dn=0.
- wrap  out  1  registered one-cycle pulse on wrap-around.
- tick  out  1  prescaler terminal pulse, exported for chaining.

## Operation
- Prescaler: DIV_EXP-bit counter, incremented every clk. tick = (prescaler == all ones). The prescaler free-runs regardless of enable.
- Priority on each rising edge: reset > load > step > hold.
- Load: count <= load_val, with any digit >9 replaced by 0. The prescaler is cleared to 0. wrap is 0. Load does not need a tick.
- Step (tick=1, enable=1, load=0):
  - Up: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
  - Down: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Wrap:
  - Up from all 9s gives all 0s; down from all 0s gives all 9s.
  - wrap <= 1 on the same edge that performs the wrapping step; it is 0 on every other edge.
- Hold: enable=0, or tick=0, leaves count unchanged.
- Decode: one combinational decoder per digit, from the registered count.
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex, 7-bit). Any other value gives 7F (blank).
  - Non-BCD values are unreachable in normal operation.

## Timing
- Reset values: count=0, prescaler=0, wrap=0, tick=0, seg7_out = 0x40 per digit, tc = ~up_dn (1 while counting down from 0).
- After reset release or load, the first step occurs on the 2^DIV_EXP-th rising edge.
- The count changes exactly once per 2^DIV_EXP cycles while enabled. count and seg7_out reflect the new value in the same cycle, with zero decode latency.
- wrap is high for exactly one clk cycle after the wrapping edge.
- up_dn changing between ticks has no effect until the next stepping edge. tc follows up_dn combinationally.
- enable deasserted on a tick cycle means that tick is lost; there is no catch-up.
- Reset asserted mid-count clears immediately (asynchronously). The count restarts from 0 with the prescaler at 0.
- load and tick in the same cycle: the load wins, and no step is taken that cycle.

## Configuration
- LEADING_ZERO_BLANK_EN defined: every digit above digit 0 whose value is 0, and whose higher digits are all 0, outputs 7F. Digit 0 is never blanked.
- LEADING_ZERO_BLANK_EN undefined: all digits always display their decoded value. count, tc and wrap are identical in both builds.

## Test plan
- Reset: DIGITS=2, assert reset mid-run → count=0x00, seg7_out=0x2040 (both digits 40), wrap=0, tick=0, immediately without a clk edge.
- Up count: DIGITS=2, DIV_EXP=2, enable=1, up_dn=1 from reset → after 40 edges count=0x10, and tick has pulsed 10 times, every 4th cycle.
- Wrap up/down:
  - load 0x99, up → after 4 edges count=0x00 and wrap high for 1 cycle.
  - load 0x00, down → count=0x99, wrap pulse, and tc=1 before the step.
- Load and sanitising: load_val=0xA5 → count=0x05. Load asserted on a tick cycle → count equals load_val, and the prescaler equals 0 on the next cycle.
- Enable hold: enable=0 for 20 edges → count unchanged and wrap=0. Toggling up_dn between ticks does not change count.
- Blanking: DIGITS=2, count=0x05:
  - with LEADING_ZERO_BLANK_EN, seg7_out[13:7]=7F and [6:0]=12.
  - without the macro, [13:7]=40.
